// File: rtl/tlul_pkg.sv
// TL-UL type definitions shared by host and device models: channel A / D structs and opcodes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsvd;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic       a_valid;
    tl_a_op_e   a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic       d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic       d_valid;
    tl_d_op_e   d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic       d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_host.sv
// Single-outstanding TL-UL host: turns a simple req/rsp command port into 32-bit Get/Put transactions.
// Latency: accept at edge N -> a_valid from N+1 -> best case rsp_valid_o at N+3; misaligned commands answer at N+1.
// Backpressure: req_ready_o only in IDLE; a_valid held stable until a_ready; RESP waits on d_valid up to TimeoutCycles.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   req_valid_i/req_ready_o   command handshake; req_we_i, req_addr_i, req_wdata_i, req_be_i command fields
//   rsp_valid_o               one-cycle response pulse; rsp_rdata_o, rsp_error_o, rsp_timeout_o held until next response
//   tl_o / tl_i               TL-UL channel A (+d_ready) out, channel D (+a_ready) in
module student_tlul_host
  import tlul_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1023,
  parameter logic [7:0]  SourceId      = 8'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  // Counter only ever holds 0 .. TimeoutCycles-1.
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;
  logic        rsp_timeout_q;

  logic        accept;
  logic        done;
  logic        done_err;
  logic        done_to;
  logic [31:0] done_rdata;
  logic        d_bad;
  logic        timeout_hit;

  // Channel D fields this host never interprets.
  logic unused_tl_i;
  assign unused_tl_i = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i & req_ready_o;

  // Opcode check depends on the direction of the outstanding command.
  assign d_bad = tl_i.d_error
               | (tl_i.d_source != SourceId)
               | (we_q ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData));

  // Fires on the RESP cycle that would bring the count up to TimeoutCycles.
  assign timeout_hit = ((32'(cnt_q) + 32'd1) >= TimeoutCycles);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done       = 1'b0;
    done_err   = 1'b0;
    done_to    = 1'b0;
    done_rdata = '0;
    unique case (state_q)
      IDLE: begin
        // A d_valid beat here (e.g. a late response) is accepted by d_ready=1 and dropped.
        if (accept) begin
          if (req_addr_i[1:0] == 2'b00) begin
            state_d = REQ;
          end else begin
            done     = 1'b1;
            done_err = 1'b1;
          end
        end
      end
      REQ: begin
        if (tl_i.a_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (tl_i.d_valid) begin
          state_d    = IDLE;
          done       = 1'b1;
          done_err   = d_bad;
          done_rdata = (!we_q && !d_bad) ? tl_i.d_data : 32'd0;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          done     = 1'b1;
          done_err = 1'b1;
          done_to  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= done;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
      if (done) begin
        rsp_rdata_q   <= done_rdata;
        rsp_error_q   <= done_err;
        rsp_timeout_q <= done_to;
      end
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;

  // Channel A is driven purely from registered state, so it is all-zero outside REQ.
  always_comb begin
    tl_o         = '0;
    tl_o.d_ready = (state_q != REQ);
    if (state_q == REQ) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = we_q ? ((be_q == 4'hF) ? PutFullData : PutPartialData) : Get;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = SourceId;
      tl_o.a_address = addr_q;
      tl_o.a_mask    = we_q ? be_q : 4'hF;
      tl_o.a_data    = we_q ? wdata_q : 32'd0;
      tl_o.a_user    = TL_A_USER_DEFAULT;
    end
  end

endmodule

// File: tb/tb_student_tlul_host.sv
// Directed bench for student_tlul_host with a hand-driven TL-UL device.
// Latency: n/a.
// Backpressure: device a_ready / d_valid driven per step.
module tb_student_tlul_host;
  import tlul_pkg::*;

  localparam logic [7:0] SRC = 8'h03;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  tl_h2d_t     tl_h2d;
  tl_d2h_t     dev;

  int checks = 0;
  int errors = 0;

  student_tlul_host #(
    .TimeoutCycles(8),
    .SourceId     (SRC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .rsp_timeout_o(rsp_timeout),
    .tl_o         (tl_h2d),
    .tl_i         (dev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, confirm it is acceptable, and let the accepting edge pass.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic d_beat(input tl_d_op_e op, input logic [7:0] src, input logic [31:0] data,
                        input logic err);
    dev.d_valid  = 1'b1;
    dev.d_opcode = op;
    dev.d_source = src;
    dev.d_data   = data;
    dev.d_error  = err;
  endtask

  tl_h2d_t exp_rst;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    dev       = '0;
    exp_rst   = '0;
    exp_rst.d_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_tl_o", tl_h2d, exp_rst);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Full write, immediate a_ready, AccessAck one cycle later
    issue(1'b1, 32'h4, 32'h3, 4'hF);
    chk("w1_a_valid", tl_h2d.a_valid, 1);
    chk("w1_a_opcode", tl_h2d.a_opcode, 0);
    chk("w1_a_mask", tl_h2d.a_mask, 4'hF);
    chk("w1_a_address", tl_h2d.a_address, 32'h4);
    chk("w1_a_data", tl_h2d.a_data, 32'h3);
    chk("w1_a_size", tl_h2d.a_size, 2);
    chk("w1_a_source", tl_h2d.a_source, SRC);
    chk("w1_d_ready_req", tl_h2d.d_ready, 0);
    chk("w1_req_ready_busy", req_ready, 0);
    dev.a_ready = 1'b1;
    tick();
    dev.a_ready = 1'b0;
    chk("w1_a_valid_resp", tl_h2d.a_valid, 0);
    chk("w1_d_ready_resp", tl_h2d.d_ready, 1);
    tick();
    chk("w1_no_rsp_yet", rsp_valid, 0);
    d_beat(AccessAck, SRC, 32'hDEAD_BEEF, 1'b0);
    tick();
    dev.d_valid = 1'b0;
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_rsp_error", rsp_error, 0);
    chk("w1_rsp_rdata", rsp_rdata, 0);
    chk("w1_rsp_timeout", rsp_timeout, 0);
    tick();
    chk("w1_rsp_pulse_end", rsp_valid, 0);

    // Read with a_ready stalled three cycles, AccessAckData 0xF0
    issue(1'b0, 32'h0, 32'h1111_1111, 4'h3);
    for (int i = 0; i < 4; i++) begin
      chk("r1_a_valid_held", tl_h2d.a_valid, 1);
      chk("r1_a_opcode", tl_h2d.a_opcode, 4);
      chk("r1_a_mask", tl_h2d.a_mask, 4'hF);
      chk("r1_a_data", tl_h2d.a_data, 0);
      chk("r1_a_address", tl_h2d.a_address, 0);
      dev.a_ready = (i == 3);
      tick();
    end
    dev.a_ready = 1'b0;
    chk("r1_a_valid_drop", tl_h2d.a_valid, 0);
    d_beat(AccessAckData, SRC, 32'hF0, 1'b0);
    tick();
    dev.d_valid = 1'b0;
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_rsp_rdata", rsp_rdata, 32'hF0);
    chk("r1_rsp_error", rsp_error, 0);
    tick();
    chk("r1_rsp_pulse_end", rsp_valid, 0);
    chk("r1_rdata_hold", rsp_rdata, 32'hF0);

    // Partial write at best-case latency: accept N, rsp at N+3
    issue(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0001);
    chk("w2_a_opcode", tl_h2d.a_opcode, 1);
    chk("w2_a_mask", tl_h2d.a_mask, 4'b0001);
    chk("w2_a_data", tl_h2d.a_data, 32'hAABB_CCDD);
    dev.a_ready = 1'b1;
    tick();
    dev.a_ready = 1'b0;
    d_beat(AccessAck, SRC, 32'h0, 1'b0);
    chk("w2_no_rsp_n2", rsp_valid, 0);
    tick();
    dev.d_valid = 1'b0;
    chk("w2_rsp_valid_n3", rsp_valid, 1);
    chk("w2_rsp_error", rsp_error, 0);
    tick();

    // Read answered with d_error
    issue(1'b0, 32'hC, 32'h0, 4'hF);
    dev.a_ready = 1'b1;
    tick();
    dev.a_ready = 1'b0;
    d_beat(AccessAckData, SRC, 32'h1234, 1'b1);
    tick();
    dev.d_valid = 1'b0;
    chk("r2_rsp_valid", rsp_valid, 1);
    chk("r2_rsp_error", rsp_error, 1);
    chk("r2_rsp_rdata", rsp_rdata, 0);
    chk("r2_rsp_timeout", rsp_timeout, 0);
    tick();

    // Read answered with the wrong d_source
    issue(1'b0, 32'h14, 32'h0, 4'hF);
    dev.a_ready = 1'b1;
    tick();
    dev.a_ready = 1'b0;
    d_beat(AccessAckData, 8'h00, 32'h5678, 1'b0);
    tick();
    dev.d_valid = 1'b0;
    chk("r3_src_error", rsp_error, 1);
    chk("r3_src_rdata", rsp_rdata, 0);
    tick();

    // Misaligned command: no bus transaction, error next cycle
    issue(1'b0, 32'h2, 32'h0, 4'hF);
    chk("mis_a_valid", tl_h2d.a_valid, 0);
    chk("mis_rsp_valid", rsp_valid, 1);
    chk("mis_rsp_error", rsp_error, 1);
    chk("mis_rsp_timeout", rsp_timeout, 0);
    chk("mis_req_ready", req_ready, 1);
    tick();
    chk("mis_pulse_end", rsp_valid, 0);

    // Timeout after 8 RESP cycles, late ack dropped, then normal command
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    dev.a_ready = 1'b1;
    tick();
    dev.a_ready = 1'b0;
    chk("to_d_ready", tl_h2d.d_ready, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_waiting", rsp_valid, 0);
    end
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_req_ready", req_ready, 1);
    d_beat(AccessAck, SRC, 32'h0, 1'b0);
    tick();
    dev.d_valid = 1'b0;
    chk("late_ack_dropped", rsp_valid, 0);
    issue(1'b1, 32'h20, 32'h55, 4'hF);
    dev.a_ready = 1'b1;
    tick();
    dev.a_ready = 1'b0;
    d_beat(AccessAck, SRC, 32'h0, 1'b0);
    tick();
    dev.d_valid = 1'b0;
    chk("post_to_rsp_valid", rsp_valid, 1);
    chk("post_to_rsp_error", rsp_error, 0);
    chk("post_to_rsp_timeout", rsp_timeout, 0);
    tick();

    // Reset pulsed while in REQ
    issue(1'b0, 32'h30, 32'h0, 4'hF);
    chk("rr_a_valid_req", tl_h2d.a_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_a_valid_async", tl_h2d.a_valid, 0);
    chk("rr_req_ready_async", req_ready, 1);
    chk("rr_d_ready_async", tl_h2d.d_ready, 1);
    tick();
    rst_n = 1'b1;
    dev.a_ready = 1'b1;
    d_beat(AccessAckData, SRC, 32'h99, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_no_rsp", rsp_valid, 0);
      chk("rr_a_valid_idle", tl_h2d.a_valid, 0);
    end
    dev = '0;
    chk("rr_req_ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
